// File: rtl/cpa_acc_pkg.sv
// Shared op codes, state encoding and flag layout for the adder sequencing stage.
// Pure declarations; no latency or flow control of its own.
package cpa_acc_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBB  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/cpa_acc_opdec.sv
// Op decode to adder operand b / carry-in, plus result flags from the settled adder outputs.
// Purely combinational; no backpressure.
module cpa_acc_opdec
  import cpa_acc_pkg::*;
(
  input  logic [2:0]   op_code_i,
  input  logic [W-1:0] d_i,
  input  logic         c_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] s_i,
  input  logic         cout_i,
  output logic [W-1:0] b_o,
  output logic         cin_o,
  output logic         uses_adder_o,
  output flags_t       res_flags_o
);

  always_comb begin
    b_o          = '0;
    cin_o        = 1'b0;
    uses_adder_o = 1'b1;
    case (op_code_i)
      OP_ADD: b_o = d_i;
      OP_ADC: begin
        b_o   = d_i;
        cin_o = c_i;
      end
      OP_SUB: begin
        b_o   = ~d_i;
        cin_o = 1'b1;
      end
      // C acts as "no borrow" so it feeds carry-in directly
      OP_SBB: begin
        b_o   = ~d_i;
        cin_o = c_i;
      end
      OP_INC: cin_o = 1'b1;
      OP_DEC: b_o = '1;
      default: uses_adder_o = 1'b0;
    endcase
  end

  assign res_flags_o.c = cout_i;
  assign res_flags_o.z = (s_i == '0);
  assign res_flags_o.v = (a_i[W-1] == b_i[W-1]) && (s_i[W-1] != a_i[W-1]);

endmodule

// File: rtl/cpa_acc_ctrl.sv
// Accumulator/flag sequencer for an external ripple adder: LOAD/CLR result 1 cycle after accept,
// arithmetic captured SETTLE_CYCLES edges after accept; op_ready low (requests ignored) while waiting.
module cpa_acc_ctrl
  import cpa_acc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] op_data,
  output logic         res_valid,
  output logic [W-1:0] acc,
  output logic         flag_c,
  output logic         flag_z,
  output logic         flag_v,
  output logic [W-1:0] cpa_a,
  output logic [W-1:0] cpa_b,
  output logic         cpa_cin,
  input  logic [W-1:0] cpa_s,
  input  logic         cpa_cout
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         cin_q;
  logic         rv_q;
  flags_t       flags_q;

  logic [W-1:0] b_d;
  logic         cin_d;
  logic         uses_adder;
  flags_t       flags_d;

  cpa_acc_opdec u_opdec (
    .op_code_i    (op_code),
    .d_i          (op_data),
    .c_i          (flags_q.c),
    .a_i          (a_q),
    .b_i          (b_q),
    .s_i          (cpa_s),
    .cout_i       (cpa_cout),
    .b_o          (b_d),
    .cin_o        (cin_d),
    .uses_adder_o (uses_adder),
    .res_flags_o  (flags_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      rv_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      rv_q <= 1'b0;
      if (state_q == IDLE) begin
        if (op_valid) begin
          if (uses_adder) begin
            a_q     <= acc_q;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end else if (op_code == OP_CLR) begin
            acc_q   <= '0;
            flags_q <= '0;
            rv_q    <= 1'b1;
          end else begin
            acc_q     <= op_data;
            flags_q.z <= (op_data == '0);
            rv_q      <= 1'b1;
          end
        end
      end else begin
        // adder inputs have been stable for SETTLE_CYCLES edges once the count hits zero
        if (cnt_q == '0) begin
          acc_q   <= cpa_s;
          flags_q <= flags_d;
          rv_q    <= 1'b1;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign res_valid = rv_q;
  assign acc       = acc_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_v    = flags_q.v;
  assign cpa_a     = a_q;
  assign cpa_b     = b_q;
  assign cpa_cin   = cin_q;

endmodule

// File: tb/tb_cpa_acc_ctrl.sv
// Bench for cpa_acc_ctrl: ideal adder attached, vector table, corner sequences, random ops.
// Every cycle all outputs are compared with a timeline/arithmetic reference model.
module tb_cpa_acc_ctrl;
  import cpa_acc_pkg::*;

  localparam int SETTLE = 2;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [3:0] op_data;
  logic       res_valid;
  logic [3:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       flag_v;
  logic [3:0] cpa_a;
  logic [3:0] cpa_b;
  logic       cpa_cin;
  logic [3:0] cpa_s;
  logic       cpa_cout;
  logic [4:0] add_sum;

  assign add_sum  = {1'b0, cpa_a} + {1'b0, cpa_b} + {4'b0, cpa_cin};
  assign cpa_s    = add_sum[3:0];
  assign cpa_cout = add_sum[4];

  cpa_acc_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_data   (op_data),
    .res_valid (res_valid),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .cpa_a     (cpa_a),
    .cpa_b     (cpa_b),
    .cpa_cin   (cpa_cin),
    .cpa_s     (cpa_s),
    .cpa_cout  (cpa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_acc, m_a, m_b, m_busy, p_acc;
  bit m_cin, m_c, m_z, m_v, m_rv, p_c, p_z, p_v;

  typedef struct {
    int op;
    int d;
    int acc;
    int c;
    int z;
    int v;
  } row_t;
  row_t rows[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_a = 0; m_b = 0; m_cin = 0;
    m_c = 0; m_z = 0; m_v = 0; m_rv = 0; m_busy = 0;
  endtask

  task automatic model_accept(input int op, input int d);
    int b;
    bit cin;
    int tot;
    int st;
    case (op)
      0: begin m_acc = d; m_z = (d == 0); m_rv = 1; end
      7: begin m_acc = 0; m_c = 0; m_z = 0; m_v = 0; m_rv = 1; end
      default: begin
        case (op)
          1: begin b = d;      cin = 0;   end
          2: begin b = d;      cin = m_c; end
          3: begin b = 15 - d; cin = 1;   end
          4: begin b = 15 - d; cin = m_c; end
          5: begin b = 0;      cin = 1;   end
          default: begin b = 15; cin = 0; end
        endcase
        m_a = m_acc; m_b = b; m_cin = cin;
        tot   = m_acc + b + int'(cin);
        p_acc = tot % 16;
        p_c   = (tot > 15);
        p_z   = (p_acc == 0);
        st    = sx(m_acc) + sx(b) + int'(cin);
        p_v   = (st > 7) || (st < -8);
        m_busy = SETTLE;
      end
    endcase
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_rv = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_acc = p_acc; m_c = p_c; m_z = p_z; m_v = p_v; m_rv = 1;
      end
    end else if (op_valid) begin
      model_accept(int'(op_code), int'(op_data));
    end
  endtask

  task automatic check_all();
    chk("op_ready",  int'(op_ready),  int'(m_busy == 0));
    chk("res_valid", int'(res_valid), int'(m_rv));
    chk("acc",       int'(acc),       m_acc);
    chk("flag_c",    int'(flag_c),    int'(m_c));
    chk("flag_z",    int'(flag_z),    int'(m_z));
    chk("flag_v",    int'(flag_v),    int'(m_v));
    chk("cpa_a",     int'(cpa_a),     m_a);
    chk("cpa_b",     int'(cpa_b),     m_b);
    chk("cpa_cin",   int'(cpa_cin),   int'(m_cin));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input int op, input int d, output int lat);
    op_valid = 1'b1;
    op_code  = 3'(op);
    op_data  = 4'(d);
    cycle();
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      cycle();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int exp_lat;

    rows[0]  = '{0, 5,  5, 0, 0, 0};
    rows[1]  = '{0, 7,  7, 0, 0, 0};
    rows[2]  = '{1, 1,  8, 0, 0, 1};
    rows[3]  = '{0, 15, 15, 0, 0, 1};
    rows[4]  = '{5, 0,  0, 1, 1, 0};
    rows[5]  = '{2, 0,  1, 0, 0, 0};
    rows[6]  = '{0, 3,  3, 0, 0, 0};
    rows[7]  = '{3, 5,  14, 0, 0, 0};
    rows[8]  = '{0, 3,  3, 0, 0, 0};
    rows[9]  = '{3, 3,  0, 1, 1, 0};
    rows[10] = '{4, 1,  15, 0, 0, 0};
    rows[11] = '{4, 1,  13, 1, 0, 0};
    rows[12] = '{6, 0,  12, 1, 0, 0};
    rows[13] = '{0, 8,  8, 1, 0, 0};
    rows[14] = '{6, 0,  7, 1, 0, 1};
    rows[15] = '{7, 9,  0, 0, 0, 0};
    rows[16] = '{1, 0,  0, 0, 1, 0};

    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_data = 4'd0;
    model_reset();
    #1;
    check_all();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Vector table
    for (int i = 0; i < 17; i++) begin
      issue(rows[i].op, rows[i].d, lat);
      exp_lat = (rows[i].op == 0 || rows[i].op == 7) ? 1 : SETTLE + 1;
      chk("row_latency", lat, exp_lat);
      chk("row_acc",    int'(acc),    rows[i].acc);
      chk("row_flag_c", int'(flag_c), rows[i].c);
      chk("row_flag_z", int'(flag_z), rows[i].z);
      chk("row_flag_v", int'(flag_v), rows[i].v);
    end

    // Reset during the second settle cycle aborts the ADD
    issue(0, 7, lat);
    op_valid = 1'b1; op_code = OP_ADD; op_data = 4'd1;
    cycle();
    op_valid = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    repeat (SETTLE + 1) cycle();
    issue(1, 3, lat);
    chk("post_reset_latency", lat, SETTLE + 1);
    chk("post_reset_acc", int'(acc), 3);

    // op_valid held high with alternating DEC/LOAD while busy
    op_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op_code = (i % 2 == 1) ? OP_LOAD : OP_DEC;
      op_data = 4'(i + 3);
      cycle();
    end
    op_valid = 1'b0;
    repeat (SETTLE + 2) cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      op_valid = ($urandom_range(0, 3) != 0);
      op_code  = 3'($urandom_range(0, 7));
      op_data  = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    op_valid = 1'b0;
    repeat (SETTLE + 2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
